// File: rtl/rotary_value_ctrl.sv
// Bounded value adjusted by rotary detent pulses, with speed acceleration and saturate/wrap bounds.
// One-cycle latency from pulse to registered value/changed/flags; always ready, no backpressure.
module rotary_value_ctrl #(
  parameter int WIDTH       = 8,
  parameter int MIN         = 0,
  parameter int MAX         = 255,
  parameter int INIT        = 0,
  parameter int STEP        = 1,
  parameter int FAST_STEP   = 8,
  parameter int FAST_WINDOW = 50000,
  parameter int FAST_COUNT  = 3,
  parameter int WRAP        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             left,
  input  logic             right,
  input  logic             load,
  input  logic             enable,
  output logic [WIDTH-1:0] value,
  output logic             changed,
  output logic             at_min,
  output logic             at_max,
  output logic             fast
);

  localparam int GW = $clog2(FAST_WINDOW + 1);
  localparam int SW = $clog2(FAST_COUNT + 1);

  localparam logic [GW-1:0]    GAP_SAT   = GW'(FAST_WINDOW);
  localparam logic [SW-1:0]    CNT_SAT   = SW'(FAST_COUNT);
  localparam logic [WIDTH:0]   MIN_X     = (WIDTH+1)'(MIN);
  localparam logic [WIDTH:0]   MAX_X     = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   FSTEP_X   = (WIDTH+1)'(FAST_STEP);
  localparam logic [WIDTH-1:0] INIT_V    = WIDTH'(INIT);
  localparam logic             INIT_MIN  = (INIT == MIN);
  localparam logic             INIT_MAX  = (INIT == MAX);
  localparam logic             WRAP_EN   = (WRAP != 0);

  logic [GW-1:0]    gap, gap_n;
  logic [SW-1:0]    streak, streak_n, streak_inc;
  logic             last_right, last_right_n;
  logic [WIDTH-1:0] value_n;
  logic             changed_n, fast_n;

  logic             accept, same_dir;
  logic [WIDTH:0]   val_x, step_x, sum_x, inc_x, dec_x;

  // Arithmetic is done one bit wider so value+step can never overflow before the bound test.
  always_comb begin
    accept     = enable && (left ^ right);
    same_dir   = (right == last_right);
    step_x     = (fast && same_dir) ? FSTEP_X : STEP_X;
    val_x      = {1'b0, value};
    sum_x      = val_x + step_x;
    streak_inc = (streak == CNT_SAT) ? streak : streak + SW'(1);

    if (sum_x <= MAX_X)      inc_x = sum_x;
    else if (val_x < MAX_X)  inc_x = MAX_X;
    else                     inc_x = WRAP_EN ? MIN_X : MAX_X;

    if (val_x >= MIN_X + step_x) dec_x = val_x - step_x;
    else if (val_x > MIN_X)      dec_x = MIN_X;
    else                         dec_x = WRAP_EN ? MAX_X : MIN_X;
  end

  always_comb begin
    value_n      = value;
    changed_n    = 1'b0;
    fast_n       = fast;
    streak_n     = streak;
    gap_n        = gap;
    last_right_n = last_right;

    if (load) begin
      value_n   = INIT_V;
      changed_n = (value != INIT_V);
      fast_n    = 1'b0;
      streak_n  = '0;
      gap_n     = GAP_SAT;
    end else begin
      if (accept) begin
        gap_n        = '0;
        streak_n     = (gap < GAP_SAT && same_dir) ? streak_inc : SW'(1);
        fast_n       = (streak_n >= CNT_SAT);
        last_right_n = right;
        value_n      = right ? inc_x[WIDTH-1:0] : dec_x[WIDTH-1:0];
      end else if (gap != GAP_SAT) begin
        gap_n = gap + GW'(1);
        // A streak dies on the same edge the gap reaches the window.
        if (gap_n == GAP_SAT) begin
          streak_n = '0;
          fast_n   = 1'b0;
        end
      end
      changed_n = (value_n != value);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value      <= INIT_V;
      changed    <= 1'b0;
      at_min     <= INIT_MIN;
      at_max     <= INIT_MAX;
      fast       <= 1'b0;
      streak     <= '0;
      gap        <= GAP_SAT;
      last_right <= 1'b1;
    end else begin
      value      <= value_n;
      changed    <= changed_n;
      at_min     <= (value_n == WIDTH'(MIN));
      at_max     <= (value_n == WIDTH'(MAX));
      fast       <= fast_n;
      streak     <= streak_n;
      gap        <= gap_n;
      last_right <= last_right_n;
    end
  end

endmodule

// File: tb/tb_rotary_value_ctrl.sv
// Directed bench for rotary_value_ctrl: vector table plus hand sequences for window expiry, wrap and async reset.
module tb_rotary_value_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left = 1'b0, right = 1'b0, load = 1'b0, enable = 1'b1;
  logic [7:0] value, w_value;
  logic       changed, at_min, at_max, fast;
  logic       w_changed, w_at_min, w_at_max, w_fast;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rotary_value_ctrl #(.WIDTH(8), .MIN(2), .MAX(20), .INIT(10), .STEP(1), .FAST_STEP(4),
                      .FAST_WINDOW(10), .FAST_COUNT(3), .WRAP(0)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .load(load), .enable(enable),
    .value(value), .changed(changed), .at_min(at_min), .at_max(at_max), .fast(fast));

  rotary_value_ctrl #(.WIDTH(8), .MIN(2), .MAX(20), .INIT(10), .STEP(1), .FAST_STEP(4),
                      .FAST_WINDOW(10), .FAST_COUNT(3), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .left(left), .right(right), .load(load), .enable(enable),
    .value(w_value), .changed(w_changed), .at_min(w_at_min), .at_max(w_at_max), .fast(w_fast));

  typedef struct {
    logic l, r, ld, en;
    int   idle;
    int   val;
    logic ch, f, mn, mx;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic l, r, ld, en, input int idle, input int val,
                     input logic ch, f, mn, mx);
    vec_t v;
    v.l = l; v.r = r; v.ld = ld; v.en = en; v.idle = idle; v.val = val;
    v.ch = ch; v.f = f; v.mn = mn; v.mx = mx;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic l, r, ld, en);
    @(negedge clk);
    left = l; right = r; load = ld; enable = en;
    @(posedge clk);
    #1;
    left = 1'b0; right = 1'b0; load = 1'b0; enable = 1'b1;
  endtask

  task automatic check_main(input string name, input int idx, input int val,
                            input logic ch, f, mn, mx);
    check({name, "_value"},   idx, int'(value),   val);
    check({name, "_changed"}, idx, int'(changed), int'(ch));
    check({name, "_fast"},    idx, int'(fast),    int'(f));
    check({name, "_at_min"},  idx, int'(at_min),  int'(mn));
    check({name, "_at_max"},  idx, int'(at_max),  int'(mx));
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i].l, vecs[i].r, vecs[i].ld, vecs[i].en);
      check_main("vec", i, vecs[i].val, vecs[i].ch, vecs[i].f, vecs[i].mn, vecs[i].mx);
      repeat (vecs[i].idle) @(posedge clk);
    end
  endtask

  initial begin
    //   l     r     ld    en   idle val ch    f     mn    mx
    add(1'b0, 1'b1, 1'b0, 1'b1, 19, 11, 1'b1, 1'b0, 1'b0, 1'b0);  // 0: slow rights
    add(1'b0, 1'b1, 1'b0, 1'b1, 19, 12, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 19, 13, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 19, 10, 1'b1, 1'b0, 1'b0, 1'b0);  // 3: load from 13
    add(1'b0, 1'b0, 1'b1, 1'b1,  0, 10, 1'b0, 1'b0, 1'b0, 1'b0);  // 4: load at INIT
    add(1'b0, 1'b1, 1'b0, 1'b1,  3, 11, 1'b1, 1'b0, 1'b0, 1'b0);  // 5: quick rights
    add(1'b0, 1'b1, 1'b0, 1'b1,  3, 12, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1,  3, 13, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1,  3, 17, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1,  0, 20, 1'b1, 1'b1, 1'b0, 1'b1);  // 9: clamp to MAX
    add(1'b0, 1'b0, 1'b1, 1'b1,  0, 10, 1'b1, 1'b0, 1'b0, 1'b0);  // 10: load from 19
    add(1'b1, 1'b1, 1'b0, 1'b1,  0, 10, 1'b0, 1'b0, 1'b0, 1'b0);  // 11: both pulses
    add(1'b0, 1'b1, 1'b0, 1'b1, 19, 11, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 19, 12, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 19, 13, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 19, 14, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 19, 15, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 19, 10, 1'b1, 1'b0, 1'b0, 1'b0);  // 17: load beats right
    add(1'b0, 1'b1, 1'b0, 1'b1,  3, 11, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1,  3, 12, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1,  3, 13, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1,  3, 12, 1'b1, 1'b0, 1'b0, 1'b0);  // 21: reversal uses STEP
    add(1'b1, 1'b0, 1'b0, 1'b1,  3, 11, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 19, 11, 1'b0, 1'b0, 1'b0, 1'b0);  // 23: disabled
    add(1'b0, 1'b0, 1'b1, 1'b1,  0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1,  3, 11, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1,  3, 12, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1,  3, 13, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1,  3, 17, 1'b1, 1'b1, 1'b0, 1'b0);  // 28: fast streak at 17

    #12;
    check_main("reset", 0, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_main("idle_after_reset", 0, 10, 1'b0, 1'b0, 1'b0, 1'b0);

    run_rows(0, 9);

    // fast must survive 9 idle edges and drop on the 10th
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      check("window_fast", i, int'(fast), (i < 10) ? 1 : 0);
    end
    check("window_value", 0, int'(value), 20);

    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check("sat_hold_value",   0, int'(value),     20);
    check("sat_hold_changed", 0, int'(changed),   0);
    check("sat_hold_at_max",  0, int'(at_max),    1);
    check("wrap_up_value",    0, int'(w_value),   2);
    check("wrap_up_changed",  0, int'(w_changed), 1);
    check("wrap_up_at_min",   0, int'(w_at_min),  1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    check("sat_dec_value",    0, int'(value),     19);
    check("wrap_dn_value",    0, int'(w_value),   20);
    check("wrap_dn_changed",  0, int'(w_changed), 1);
    check("wrap_dn_at_max",   0, int'(w_at_max),  1);

    run_rows(10, 28);

    // asynchronous reset mid-cycle, away from any clock edge
    #3;
    rst = 1'b1;
    #1;
    check_main("async_rst", 0, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check_main("post_rst", 0, 11, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotary_value_ctrl.md
Name: rotary_value_ctrl

Overview:
- Downstream consumer of the rotary decoder's one-cycle `left`/`right` direction pulses.
- Maintains a bounded user-adjustable value: right increments, left decrements.
- Bound behaviour is saturating or wrapping, selected by parameter.
- Speed acceleration: a fast streak of same-direction detents switches to a larger step.
- Drives display/setpoint logic with the value and a one-cycle change strobe.

Parameters:
- WIDTH, 8, bit width of value.
- MIN, 0, lower bound.
- MAX, 255, upper bound.
- INIT, 0, value after reset/load.
- STEP, 1, normal step.
- FAST_STEP, 8, accelerated step.
- FAST_WINDOW, 50000, max cycles between detents counted as "fast".
- FAST_COUNT, 3, consecutive fast same-direction detents before acceleration.
- WRAP, 0, 0 = saturate at bounds, 1 = wrap (see Behaviour).
- Constraints: MIN <= INIT <= MAX < 2^WIDTH; STEP >= 1; FAST_STEP >= STEP; FAST_COUNT >= 1; FAST_WINDOW >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- left  in  1  one-cycle decrement pulse (clk domain)
- right  in  1  one-cycle increment pulse (clk domain)
- load  in  1  one-cycle pulse, restore INIT
- enable  in  1  1 = accept left/right events
- value  out  WIDTH  current value
- changed  out  1  one-cycle pulse, value changed this cycle
- at_min  out  1  value == MIN
- at_max  out  1  value == MAX
- fast  out  1  acceleration active

Behaviour:
- Reset (async, immediate, no clock needed): value=INIT, changed=0, fast=0, streak=0, gap counter=FAST_WINDOW (saturated), last direction=right; at_min/at_max reflect INIT.
- All outputs registered. A pulse at edge N updates value/changed/flags at edge N (visible in cycle N+1); latency is 1 cycle.
- Event accepted when enable=1 and exactly one of left/right is high. left & right together → no event: value held, changed=0, streak unchanged.
- enable=0: left/right ignored; gap counter keeps running.
- load has priority over everything:
  - value=INIT, streak=0, fast=0, gap saturated.
  - changed=1 only if the old value != INIT.
- Gap counter:
  - Clears to 0 on each accepted event.
  - Otherwise increments, saturating at FAST_WINDOW.
  - Reaching FAST_WINDOW clears streak and fast on that same edge.
- Streak on an accepted event:
  - If gap < FAST_WINDOW and direction equals last direction: streak+1, saturating at FAST_COUNT.
  - Else: streak=1.
  - fast := (new streak >= FAST_COUNT). Last direction is updated.
- Step: FAST_STEP if pre-event fast=1 and same direction as last; otherwise STEP. Pre-event registered fast is used. A reversal always uses STEP and drops fast.
- Arithmetic: computed in WIDTH+1 bits, no intermediate overflow.
  - Increment: value+step <= MAX → value+step. Else if value < MAX → MAX (clamp). Else (value == MAX): WRAP=0 holds MAX, WRAP=1 → MIN.
  - Decrement: mirror of increment. value-step >= MIN → value-step. Else if value > MIN → MIN. Else (value == MIN): WRAP=0 holds, WRAP=1 → MAX.
- changed=1 exactly on edges where value register changes value; a held value at a bound gives no pulse.
- at_min/at_max are always consistent with value in the same cycle.

Test Plan (MIN=2, MAX=20, INIT=10, STEP=1, FAST_STEP=4, FAST_WINDOW=10, FAST_COUNT=3, enable=1):
1. After reset, 3 right pulses 20 cycles apart → value 11,12,13; one changed pulse each, 1 cycle after each pulse; fast stays 0.
2. From 10, 5 right pulses 4 cycles apart → value 11,12,13,17,20 (last one clamped); fast=1 after 3rd pulse; fast=0 exactly 10 idle cycles after last pulse.
3. WRAP=0 at value 20: right → value 20, changed=0, at_max=1. WRAP=1 at 20: right → value 2, changed=1, at_min=1. WRAP=1 at 2: left → 20.
4. left and right high in the same cycle at value 10 → value 10, changed=0. load with right same cycle at value 15 → value 10, changed=1. load at value 10 → changed=0.
5. With fast=1 after 3 quick rights from 10 (value 13), left 4 cycles later → value 12 (STEP), fast=0. Next quick left → 11, fast still 0.
6. Async rst asserted mid-cycle during a fast streak at value 17 → value=10, fast=0, changed=0 immediately with no clock edge. After release, one right → 11 with STEP.
